// File: rtl/arc4_pkg.sv
// Shared constants and checker state encoding for the S-memory init/check pair.
package arc4_pkg;

  localparam int S_DEPTH = 256;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;

  localparam logic [ADDR_W-1:0] ADDR_LAST = 8'd255;
  localparam logic [ADDR_W:0]   ERR_MAX   = 9'd256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2
  } chk_state_e;

endpackage

// File: rtl/init_check.sv
// Read-side checker: sweeps S[0..255] through a 1-cycle synchronous read port
// and verifies S[i]==i, reporting error count, first bad address and pass.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | rdy=1, results held, addr held; en starts a sweep
// RUN     | addr 0..255 issued one per cycle, compare one cycle behind
// LAST    | compare final datum; done pulses on the way back to IDLE
module init_check
  import arc4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rddata,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] err_addr
);

  chk_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic              cmp_vld_q, cmp_vld_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ADDR_W:0]   err_count_q, err_count_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              mismatch;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    // Expected value trails the issued address by one cycle, matching read latency.
    exp_d       = addr_q;
    cmp_vld_d   = (state_q == ST_RUN);
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;

    mismatch = cmp_vld_q && (rddata != exp_q);
    if (mismatch) begin
      if (err_count_q != ERR_MAX) err_count_d = err_count_q + 9'd1;
      if (err_count_q == '0)      err_addr_d  = exp_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d     = ST_RUN;
          addr_d      = '0;
          err_count_d = '0;
          err_addr_d  = '0;
          pass_d      = 1'b0;
        end
      end
      ST_RUN: begin
        if (addr_q == ADDR_LAST) state_d = ST_LAST;
        else                     addr_d  = addr_q + 8'd1;
      end
      ST_LAST: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        pass_d  = (err_count_d == '0);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      exp_q       <= '0;
      cmp_vld_q   <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      exp_q       <= exp_d;
      cmp_vld_q   <= cmp_vld_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign rdy       = (state_q == ST_IDLE);
  assign addr      = addr_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;

endmodule

// File: doc/init_check.md
INIT_CHECK -- requirements
Module: init_check

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 en  input  1  start request, honoured only in a cycle where rdy=1.
REQ-005 rdy  output  1  1 = idle and able to accept en.
REQ-006 addr  output  8  S-memory read address.
REQ-007 rddata  input  8  S-memory read data; valid in the cycle after the one in which addr was driven (1-cycle synchronous read).
REQ-008 done  output  1  one-cycle pulse on completion of a sweep.
REQ-009 pass  output  1  1 = every location satisfied S[i]==i in the last sweep.
REQ-010 err_count  output  9  number of mismatching locations in the last sweep (0..256).
REQ-011 err_addr  output  8  lowest mismatching address in the last sweep; 0 if none.

Function
REQ-012 The module SHALL be the read-side counterpart of the init writer: it reads S[0..255] and checks that S[i]==i.
REQ-013 States SHALL be IDLE, RUN and LAST.
  - IDLE: rdy=1.
  - RUN: rdy=0; issues addresses 0..255.
  - LAST: rdy=0; compares the final datum.
REQ-014 Start: en=1 sampled at a rising edge while in IDLE, call it cycle 0 → RUN, addr=0, and err_count, err_addr and pass SHALL be cleared at that edge.
REQ-015 In RUN, addr SHALL increment by 1 each cycle: addr=k in cycle k+1, for k=0..255.
REQ-016 In cycle c (c=2..257), rddata SHALL be compared with c-2, the address driven in cycle c-1.
REQ-017 RUN→LAST SHALL occur after addr=255 has been driven (entering cycle 257); LAST→IDLE SHALL follow unconditionally (cycle 258).
REQ-018 No compare SHALL occur in cycle 1, because no read is outstanding.
REQ-019 On a mismatch:
  - err_count SHALL increment by 1, saturating at 256 (unreachable otherwise, but required).
  - err_addr SHALL be loaded only on the first mismatch of the sweep.
REQ-020 In cycle 258, done=1, rdy=1, and pass SHALL equal (err_count==0).
REQ-021 pass, err_count and err_addr SHALL hold until the next accepted start.
REQ-022 en while rdy=0 SHALL be ignored; the sweep is not restarted or extended.
REQ-023 en held high continuously SHALL start the next sweep in cycle 258. The done pulse in that cycle still shows the completed sweep's results; they are cleared at the following edge.
REQ-024 addr SHALL hold its last value while in IDLE.
REQ-025 The module SHALL never write the memory.
REQ-026 Each sweep SHALL read all 256 locations regardless of mismatches; there is no early exit.

Reset
REQ-027 While rst_n=0, the outputs SHALL be: state=IDLE, rdy=1, addr=0, done=0, pass=0, err_count=0, err_addr=0.
REQ-028 Reset asserted mid-sweep SHALL abort immediately; no done pulse SHALL follow.
REQ-029 After reset release, the first accepted en SHALL start a full sweep from addr 0.

Structure
REQ-030 The shared package arc4_pkg SHALL hold S_DEPTH=256, ADDR_W=8, DATA_W=8, and the checker state enum.
REQ-031 The module SHALL be a single module with no sub-module.
REQ-032 The module SHALL contain a single registered address counter and a 1-cycle expected-value pipeline register feeding the comparator.

Verification
REQ-033 The bench SHALL include an 8-bit, 256-entry, 1-cycle-latency memory model, and SHALL cover:
  - V1: memory S[i]=i; reset; en=1 for one cycle → rdy low for cycles 1..257; done=1, pass=1, err_count=0 in cycle 258.
  - V2: S[i]=i except S[0x10]=0xFF and S[0xC8]=0x00 → pass=0, err_count=2, err_addr=0x10.
  - V3: S[i]=255-i → err_count=256, err_addr=0x00, pass=0.
  - V4: rst_n=0 at cycle 100 of a sweep → rdy=1, addr=0, done never pulses; a new en gives a clean full sweep with pass=1.
  - V5: en held high throughout with a correct memory → done pulses every 258 cycles; rdy is high only in the done cycle; addr runs 0..255 each sweep.
  - V6: en pulsed at cycle 50 of a sweep → no effect; exactly one done pulse at cycle 258; results are unchanged.
